// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter in front of a fixed-latency
//               main memory; one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 4,   // legal range 1..15
    parameter int AW      = 16,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req0,
    input  logic          i_rw0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    input  logic          i_req1,
    input  logic          i_rw1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_mem_strobe,
    output logic          o_mem_rw,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_rdy0,
    output logic          o_rdy1,
    output logic [DW-1:0] o_rdata,
    output logic          o_busy
);

    localparam int                 c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_win;
    logic                r_rr_pri;
    logic                r_mem_strobe;
    logic                r_mem_rw;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_wdata;
    logic                r_rdy0;
    logic                r_rdy1;
    logic [DW-1:0]       r_rdata;
    logic                r_busy;

    logic                w_any_req;
    logic                w_win;

    // r_rr_pri names the requester that wins a tie; a lone requester always wins.
    always_comb begin
        w_any_req = i_req0 | i_req1;
        w_win     = (i_req0 & i_req1) ? r_rr_pri : i_req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_win        <= 1'b0;
            r_rr_pri     <= 1'b0;
            r_mem_strobe <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdy0       <= 1'b0;
            r_rdy1       <= 1'b0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_GRANT;
                        r_win        <= w_win;
                        r_mem_rw     <= w_win ? i_rw1    : i_rw0;
                        r_mem_addr   <= w_win ? i_addr1  : i_addr0;
                        r_mem_wdata  <= w_win ? i_wdata1 : i_wdata0;
                        r_mem_strobe <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_GRANT: begin
                    r_mem_strobe <= 1'b0;
                    r_cnt        <= c_CNT_LOAD;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        // Memory presents read data during the final wait cycle.
                        if (r_mem_rw) begin
                            r_rdata <= i_mem_rdata;
                        end
                        r_rdy0  <= ~r_win;
                        r_rdy1  <= r_win;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_rdy0   <= 1'b0;
                    r_rdy1   <= 1'b0;
                    r_rr_pri <= ~r_win;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_strobe = r_mem_strobe;
    assign o_mem_rw     = r_mem_rw;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_rdy0       = r_rdy0;
    assign o_rdy1       = r_rdy1;
    assign o_rdata      = r_rdata;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 4, main-memory access latency in cycles; legal range 1..15.
REQ-002 Parameter: AW, default 16, address width.
REQ-003 Parameter: DW, default 32, data width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 req0  in  1  requester-0 memory strobe (cache controller MStrobe), held high until rdy0.
REQ-006 rw0  in  1  requester-0 direction, 1=read, 0=write.
REQ-007 addr0  in  AW  requester-0 address; wdata0  in  DW  requester-0 write data.
REQ-008 req1, rw1, addr1, wdata1: same as REQ-005..007, for requester 1.
REQ-009 mem_strobe  out  1  one-cycle main-memory start pulse.
REQ-010 mem_rw  out  1  main-memory direction, 1=read.
REQ-011 mem_addr  out  AW; mem_wdata  out  DW  main-memory address/data, registered.
REQ-012 mem_rdata  in  DW  main-memory read data, valid in last wait cycle.
REQ-013 rdy0, rdy1  out  1  one-cycle completion pulse to the granted requester.
REQ-014 rdata  out  DW  captured read data, valid while rdyN is high and held until the next capture.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, WAIT, DONE.
REQ-017 IDLE: if any req high at a clock edge, SHALL move to GRANT, latch winner id, rw, addr, wdata into output registers; else stay.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; after reset requester 0 has priority.
REQ-019 A single requesting input SHALL win regardless of the round-robin pointer.
REQ-020 GRANT: mem_strobe=1 for exactly this one cycle; wait counter loaded with MEM_LAT-1; next state WAIT.
REQ-021 WAIT: counter decrements each cycle; when counter==0, SHALL capture mem_rdata into rdata (reads only) and move to DONE.
REQ-022 DONE: assert rdy of the latched winner for exactly one cycle; update round-robin pointer to favour the other requester; next state IDLE.
REQ-023 Latency: req sampled at edge E -> mem_strobe high in cycle after E -> rdyN high MEM_LAT+1 cycles after mem_strobe.
REQ-024 A request arriving in DONE SHALL NOT be granted before IDLE (one IDLE cycle minimum between transactions).
REQ-025 A request deasserted mid-transaction SHALL NOT abort the transaction; it completes and rdy still pulses.
REQ-026 Requests, rw, addr, wdata changing after grant SHALL NOT affect mem_rw, mem_addr, mem_wdata until the next grant.
REQ-027 Writes SHALL leave rdata unchanged.
REQ-028 rdy0 and rdy1 SHALL never be high in the same cycle; mem_strobe SHALL never be high outside GRANT.

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, force: state IDLE, mem_strobe=0, mem_rw=0, mem_addr=0, mem_wdata=0, rdy0=0, rdy1=0, rdata=0, busy=0, counter=0, round-robin pointer favouring requester 0.
REQ-030 Reset during GRANT/WAIT/DONE SHALL abandon the transaction with no rdy pulse; after release, a still-high request is re-arbitrated from IDLE.

Verification
REQ-031 MEM_LAT=4, req0=1 rw0=1 addr0=0x0040 alone, mem_rdata=0xDEADBEEF -> mem_strobe 1 cycle after grant edge, mem_addr=0x0040, rdy0 pulse 5 cycles after mem_strobe, rdata=0xDEADBEEF.
REQ-032 req0 and req1 high together continuously -> grants alternate 0,1,0,1; rdy0/rdy1 never overlap.
REQ-033 req1 write addr1=0x1234 wdata1=0xA5A5A5A5, rdata previously 0x11111111 -> mem_rw=0, mem_wdata=0xA5A5A5A5, rdy1 pulses, rdata stays 0x11111111.
REQ-034 addr0 changed 0x0040->0x0080 during WAIT -> mem_addr stays 0x0040 until rdy0.
REQ-035 rst_n low in WAIT second cycle with req0 still high -> outputs zero immediately, no rdy0; after release, new grant to requester 0 with full MEM_LAT latency.
REQ-036 MEM_LAT=1, back-to-back req0 -> mem_strobe, 1 WAIT cycle, rdy0, IDLE, next mem_strobe; period 4 cycles.
